// File: rtl/wb_cmd_master.sv
// Wishbone classic master engine: runs queued WRITE/READ/WAIT_IRQ commands in order, one response per command,
// with a per-command wait timeout that turns a missing ack or missing irq edge into an error response.
module wb_cmd_master #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  ack_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  irq_i,
    output logic                  busy_o
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic          TMO_EN   = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_WIRQ, ST_GAP} state_t;

    state_t                r_state;
    logic                  r_cyc;
    logic                  r_stb;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [TW-1:0]         r_tmo;
    logic                  r_irq_q;

    logic [1:0]            r_cmd_op  [CMD_DEPTH];
    logic [ADDR_WIDTH-1:0] r_cmd_adr [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] r_cmd_dat [CMD_DEPTH];
    logic [CAW:0]          r_cmd_wp;
    logic [CAW:0]          r_cmd_rp;

    logic [DATA_WIDTH-1:0] r_rsp_dat [RSP_DEPTH];
    logic                  r_rsp_err [RSP_DEPTH];
    logic [RAW:0]          r_rsp_wp;
    logic [RAW:0]          r_rsp_rp;

    logic                  w_cmd_empty;
    logic                  w_cmd_full;
    logic                  w_cmd_push;
    logic                  w_rsp_empty;
    logic                  w_rsp_full;
    logic                  w_rsp_pop;
    logic                  w_launch;
    logic [1:0]            w_head_op;
    logic [ADDR_WIDTH-1:0] w_head_adr;
    logic [DATA_WIDTH-1:0] w_head_dat;
    logic                  w_waiting;
    logic                  w_done_bus;
    logic                  w_done_irq;
    logic                  w_tmo_hit;
    logic                  w_rsp_push;
    logic                  w_rsp_err;
    logic [DATA_WIDTH-1:0] w_rsp_dat;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_cmd_empty = (r_cmd_wp == r_cmd_rp);
    assign w_cmd_full  = (r_cmd_wp[CAW] != r_cmd_rp[CAW]) && (r_cmd_wp[CAW-1:0] == r_cmd_rp[CAW-1:0]);
    assign w_cmd_push  = cmd_valid_i && !w_cmd_full;
    assign w_rsp_empty = (r_rsp_wp == r_rsp_rp);
    assign w_rsp_full  = (r_rsp_wp[RAW] != r_rsp_rp[RAW]) && (r_rsp_wp[RAW-1:0] == r_rsp_rp[RAW-1:0]);
    assign w_rsp_pop   = !w_rsp_empty && rsp_ready_i;

    assign w_head_op  = r_cmd_op[r_cmd_rp[CAW-1:0]];
    assign w_head_adr = r_cmd_adr[r_cmd_rp[CAW-1:0]];
    assign w_head_dat = r_cmd_dat[r_cmd_rp[CAW-1:0]];

    // A free response slot is reserved at launch, so the eventual push can never overflow.
    assign w_launch   = (r_state == ST_IDLE) && !w_cmd_empty && !w_rsp_full;
    assign w_waiting  = (r_state == ST_BUS) || (r_state == ST_WIRQ);
    assign w_done_bus = (r_state == ST_BUS) && ack_i;
    assign w_done_irq = (r_state == ST_WIRQ) && irq_i && !r_irq_q;
    assign w_tmo_hit  = TMO_EN && w_waiting && (r_tmo == TMO_LAST);
    assign w_rsp_push = w_done_bus || w_done_irq || w_tmo_hit;
    assign w_rsp_err  = !(w_done_bus || w_done_irq);
    assign w_rsp_dat  = (w_done_bus && !r_we) ? dat_i : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cmd_wp <= '0;
            r_cmd_rp <= '0;
            r_rsp_wp <= '0;
            r_rsp_rp <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wp <= r_cmd_wp + 1'b1;
            if (w_launch)   r_cmd_rp <= r_cmd_rp + 1'b1;
            if (w_rsp_push) r_rsp_wp <= r_rsp_wp + 1'b1;
            if (w_rsp_pop)  r_rsp_rp <= r_rsp_rp + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_cmd_push) begin
            r_cmd_op[r_cmd_wp[CAW-1:0]]  <= cmd_op_i;
            r_cmd_adr[r_cmd_wp[CAW-1:0]] <= cmd_adr_i;
            r_cmd_dat[r_cmd_wp[CAW-1:0]] <= cmd_dat_i;
        end
        if (w_rsp_push) begin
            r_rsp_dat[r_rsp_wp[RAW-1:0]] <= w_rsp_dat;
            r_rsp_err[r_rsp_wp[RAW-1:0]] <= w_rsp_err;
        end
    end

    // Sequencer: IDLE -> BUS/WIRQ -> GAP -> IDLE; GAP guarantees two low cycles of cyc_o between commands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_tmo   <= '0;
            r_irq_q <= 1'b0;
        end else begin
            r_irq_q <= irq_i;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_tmo <= '0;
                        if (w_head_op[1]) begin
                            r_state <= ST_WIRQ;
                        end else begin
                            r_state <= ST_BUS;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_we    <= !w_head_op[0];
                            r_adr   <= w_head_adr;
                            r_dat   <= w_head_op[0] ? '0 : w_head_dat;
                        end
                    end
                end
                ST_BUS, ST_WIRQ: begin
                    if (w_rsp_push) begin
                        r_state <= ST_GAP;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_adr   <= '0;
                        r_dat   <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_GAP:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = !w_cmd_full;
    assign rsp_valid_o = !w_rsp_empty;
    assign rsp_dat_o   = w_rsp_empty ? '0 : r_rsp_dat[r_rsp_rp[RAW-1:0]];
    assign rsp_err_o   = w_rsp_empty ? 1'b0 : r_rsp_err[r_rsp_rp[RAW-1:0]];
    assign cyc_o       = r_cyc;
    assign stb_o       = r_stb;
    assign we_o        = r_we;
    assign adr_o       = r_adr;
    assign dat_o       = r_dat;
    assign busy_o      = (r_state != ST_IDLE) || !w_cmd_empty;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: vector table of single commands plus multi-cycle corner sequences.
module tb_wb_cmd_master;

    logic       clk;
    logic       rst;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i;
    logic [1:0] cmd_adr_i;
    logic [7:0] cmd_dat_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [7:0] rsp_dat_o;
    logic       rsp_err_o;
    logic       cyc_o;
    logic       stb_o;
    logic       we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic       ack_i;
    logic [7:0] dat_i;
    logic       irq_i;
    logic       busy_o;

    wb_cmd_master #(
        .ADDR_WIDTH(2), .DATA_WIDTH(8), .CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .dat_i(dat_i), .irq_i(irq_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [1:0] adr;
        logic [7:0] dat;
        int         wt;
        logic [7:0] rd;
        logic       err;
        logic [7:0] rdat;
        int         len;
        logic       ewe;
        logic [7:0] edat;
    } vec_t;

    vec_t vecs[8];
    int   n_tests;
    int   n_fail;

    // Slave model configuration (written by main) and monitor results (written by monitor).
    int       slv_wait;
    logic [7:0] slv_rdata;
    logic     force_ack;
    int       s_cnt;
    int       mon_total;
    int       mon_bus;
    int       mon_gap;
    int       idle_run;
    logic     prev_cyc;
    logic       cap_we;
    logic [1:0] cap_adr;
    logic [7:0] cap_dat;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d);
        cmd_op_i    = op;
        cmd_adr_i   = a;
        cmd_dat_i   = d;
        cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic pop();
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic wait_rsp(output int ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_o) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Wishbone slave: acks after slv_wait wait states, drives slv_rdata with the ack.
    initial begin
        ack_i = 1'b0;
        dat_i = 8'h00;
        s_cnt = 0;
        forever begin
            @(negedge clk);
            if (cyc_o && stb_o && !ack_i) begin
                if (s_cnt == slv_wait) begin
                    ack_i = 1'b1;
                    dat_i = slv_rdata;
                end else begin
                    s_cnt++;
                end
            end else begin
                ack_i = force_ack;
                dat_i = 8'h00;
                s_cnt = 0;
            end
        end
    end

    // Bus monitor: cycles with cyc_o high, bus cycle count, idle gap before the latest cycle, captured fields.
    initial begin
        mon_total = 0;
        mon_bus   = 0;
        mon_gap   = 0;
        idle_run  = 0;
        prev_cyc  = 1'b0;
        cap_we    = 1'b0;
        cap_adr   = 2'd0;
        cap_dat   = 8'h00;
        forever begin
            @(negedge clk);
            if (cyc_o) begin
                mon_total++;
                if (!prev_cyc) begin
                    mon_bus++;
                    mon_gap = idle_run;
                end
                cap_we   = we_o;
                cap_adr  = adr_o;
                cap_dat  = dat_o;
                idle_run = 0;
            end else begin
                idle_run++;
            end
            prev_cyc = cyc_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ok;
        int base;
        int npop;
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'b00;
        cmd_adr_i   = 2'd0;
        cmd_dat_i   = 8'h00;
        rsp_ready_i = 1'b0;
        irq_i       = 1'b0;
        force_ack   = 1'b0;
        slv_wait    = 0;
        slv_rdata   = 8'h00;

        //            op     adr   dat    wt   rd     err   rdat   len ewe   edat
        vecs[0] = '{2'b00, 2'd2, 8'hA5, 3,   8'h00, 1'b0, 8'h00, 4,  1'b1, 8'hA5};
        vecs[1] = '{2'b01, 2'd1, 8'h00, 0,   8'h3C, 1'b0, 8'h3C, 1,  1'b0, 8'h00};
        vecs[2] = '{2'b00, 2'd0, 8'h5A, 0,   8'h00, 1'b0, 8'h00, 1,  1'b1, 8'h5A};
        vecs[3] = '{2'b01, 2'd3, 8'hEE, 5,   8'hC3, 1'b0, 8'hC3, 6,  1'b0, 8'h00};
        vecs[4] = '{2'b01, 2'd2, 8'h00, 255, 8'h99, 1'b1, 8'h00, 16, 1'b0, 8'h00};
        vecs[5] = '{2'b00, 2'd1, 8'hFF, 15,  8'h00, 1'b0, 8'h00, 16, 1'b1, 8'hFF};
        vecs[6] = '{2'b01, 2'd0, 8'h00, 15,  8'h81, 1'b0, 8'h81, 16, 1'b0, 8'h00};
        vecs[7] = '{2'b11, 2'd3, 8'h42, 0,   8'h00, 1'b1, 8'h00, 0,  1'b0, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", cyc_o, 0);
        check("rst_stb", stb_o, 0);
        check("rst_we", we_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_rsp_dat", rsp_dat_o, 0);
        check("rst_rsp_err", rsp_err_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", cmd_ready_o, 1);

        // Stray ack with no cycle open must not produce anything.
        force_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("stray_ack_rsp", rsp_valid_o, 0);
        check("stray_ack_busy", busy_o, 0);
        force_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Launch latency: push at edge N, cyc_o high only after edge N+1.
        slv_wait = 0;
        push(2'b00, 2'd1, 8'h11);
        check("lat_edge_n", cyc_o, 0);
        @(posedge clk); #1;
        check("lat_edge_n1", cyc_o, 1);
        wait_rsp(ok);
        check("lat_rsp", ok, 1);
        pop();
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            slv_wait  = vecs[i].wt;
            slv_rdata = vecs[i].rd;
            base      = mon_total;
            push(vecs[i].op, vecs[i].adr, vecs[i].dat);
            wait_rsp(ok);
            check($sformatf("v%0d_rsp", i), ok, 1);
            check($sformatf("v%0d_err", i), rsp_err_o, vecs[i].err);
            check($sformatf("v%0d_dat", i), rsp_dat_o, vecs[i].rdat);
            check($sformatf("v%0d_len", i), mon_total - base, vecs[i].len);
            if (vecs[i].len > 0) begin
                check($sformatf("v%0d_we", i), cap_we, vecs[i].ewe);
                check($sformatf("v%0d_adr", i), cap_adr, vecs[i].adr);
                check($sformatf("v%0d_wdat", i), cap_dat, vecs[i].edat);
            end
            pop();
            check($sformatf("v%0d_popped", i), rsp_valid_o, 0);
            repeat (3) @(posedge clk);
            #1;
        end

        // Back-to-back commands: cyc_o stays low exactly two cycles between them.
        slv_wait  = 0;
        slv_rdata = 8'h44;
        push(2'b01, 2'd0, 8'h00);
        push(2'b01, 2'd3, 8'h00);
        repeat (12) @(posedge clk);
        #1;
        check("b2b_gap", mon_gap, 2);
        check("b2b_rsp0", rsp_valid_o, 1);
        check("b2b_dat0", rsp_dat_o, 8'h44);
        pop();
        check("b2b_rsp1", rsp_valid_o, 1);
        pop();
        check("b2b_empty", rsp_valid_o, 0);

        // Timeout on a READ, then the queued WRITE still runs.
        slv_wait = 255;
        push(2'b01, 2'd2, 8'h00);
        push(2'b00, 2'd3, 8'h77);
        wait_rsp(ok);
        slv_wait = 0;
        check("tmo_rsp", ok, 1);
        check("tmo_err", rsp_err_o, 1);
        check("tmo_dat", rsp_dat_o, 0);
        pop();
        wait_rsp(ok);
        check("tmo_next_rsp", ok, 1);
        check("tmo_next_err", rsp_err_o, 0);
        check("tmo_next_wdat", cap_dat, 8'h77);
        check("tmo_next_adr", cap_adr, 2'd3);
        pop();
        repeat (3) @(posedge clk);
        #1;

        // WAIT_IRQ: earlier pulse forgotten, pulse 10 cycles after entry completes it.
        irq_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        irq_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(2'b10, 2'd0, 8'h00);
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        check("wirq_pending", rsp_valid_o, 0);
        check("wirq_busy", busy_o, 1);
        check("wirq_no_cyc", cyc_o, 0);
        irq_i = 1'b1;
        @(posedge clk); #1;
        check("wirq_rsp", rsp_valid_o, 1);
        check("wirq_err", rsp_err_o, 0);
        check("wirq_dat", rsp_dat_o, 0);
        irq_i = 1'b0;
        pop();
        repeat (3) @(posedge clk);
        #1;

        // irq level already high at entry is not an edge: the wait times out.
        irq_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push(2'b10, 2'd0, 8'h00);
        wait_rsp(ok);
        check("wirq_level_rsp", ok, 1);
        check("wirq_level_err", rsp_err_o, 1);
        irq_i = 1'b0;
        pop();
        repeat (3) @(posedge clk);
        #1;

        // Response FIFO full stalls the engine; command FIFO fills behind it.
        slv_wait = 0;
        base     = mon_bus;
        for (int k = 0; k < 5; k++) push(2'b00, 2'(k), 8'(k + 1));
        repeat (40) @(posedge clk);
        #1;
        check("fill_bus4", mon_bus - base, 4);
        check("fill_rsp_valid", rsp_valid_o, 1);
        check("fill_busy", busy_o, 1);
        check("fill_ready_3free", cmd_ready_o, 1);
        for (int k = 0; k < 3; k++) push(2'b00, 2'd0, 8'h00);
        check("fill_ready_full", cmd_ready_o, 0);
        pop();
        repeat (6) @(posedge clk);
        #1;
        check("fill_bus5", mon_bus - base, 5);
        check("fill_ready_again", cmd_ready_o, 1);
        npop        = 0;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (rsp_valid_o) npop++;
            @(posedge clk); #1;
        end
        rsp_ready_i = 1'b0;
        check("fill_drain", npop, 7);
        check("fill_bus8", mon_bus - base, 8);

        // Asynchronous reset in the middle of a bus cycle.
        slv_wait = 255;
        push(2'b01, 2'd1, 8'h00);
        repeat (3) @(posedge clk);
        #3;
        check("mid_cyc_high", cyc_o, 1);
        rst = 1'b1;
        #1;
        check("arst_cyc", cyc_o, 0);
        check("arst_stb", stb_o, 0);
        check("arst_rsp", rsp_valid_o, 0);
        check("arst_busy", busy_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        slv_wait = 0;
        repeat (5) @(posedge clk);
        #1;
        check("arst_after_cyc", cyc_o, 0);
        check("arst_after_rsp", rsp_valid_o, 0);
        check("arst_after_ready", cmd_ready_o, 1);
        push(2'b00, 2'd2, 8'h3A);
        wait_rsp(ok);
        check("arst_recover_rsp", ok, 1);
        check("arst_recover_err", rsp_err_o, 0);
        pop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
